// File: rtl/reorder_buffer_mc.sv
// Reorder buffer: in-order allocation, multi-port out-of-order writeback,
// up to COMMIT_WIDTH in-order retirements per cycle, registered flush on mispredict/jalr.
module reorder_buffer_mc #(
   parameter int IDX_BITS     = 4,
   parameter int WB_PORTS     = 2,
   parameter int COMMIT_WIDTH = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         rdy_in,
   input  logic                         alloc_valid,
   output logic                         alloc_ready,
   input  logic [1:0]                   alloc_kind,
   input  logic [4:0]                   alloc_rd,
   input  logic [31:0]                  alloc_value,
   input  logic [31:0]                  alloc_alt_pc,
   input  logic                         alloc_pred_taken,
   output logic [IDX_BITS-1:0]          alloc_id,
   input  logic [WB_PORTS-1:0]          wb_valid,
   input  logic [WB_PORTS*IDX_BITS-1:0] wb_id,
   input  logic [WB_PORTS*32-1:0]       wb_value,
   input  logic [IDX_BITS-1:0]          q_id_a,
   input  logic [IDX_BITS-1:0]          q_id_b,
   output logic                         q_ready_a,
   output logic                         q_ready_b,
   output logic [31:0]                  q_value_a,
   output logic [31:0]                  q_value_b,
   output logic [COMMIT_WIDTH-1:0]      commit_valid,
   output logic [COMMIT_WIDTH*IDX_BITS-1:0] commit_id,
   output logic [COMMIT_WIDTH*5-1:0]    commit_rd,
   output logic [COMMIT_WIDTH*32-1:0]   commit_value,
   output logic                         store_commit,
   output logic                         flush_valid,
   output logic [31:0]                  flush_pc,
   output logic                         jalr_pending,
   output logic [IDX_BITS:0]            count,
   output logic                         empty
);

   localparam int DEPTH = 2**IDX_BITS;
   localparam logic [IDX_BITS:0] DEPTH_CNT = (IDX_BITS+1)'(DEPTH);
   localparam logic [1:0] K_REG    = 2'd0;
   localparam logic [1:0] K_STORE  = 2'd1;
   localparam logic [1:0] K_BRANCH = 2'd2;
   localparam logic [1:0] K_JALR   = 2'd3;

   logic [DEPTH-1:0]    ent_valid;
   logic [DEPTH-1:0]    ent_done;
   logic [DEPTH-1:0]    ent_pred;
   logic [1:0]          ent_kind   [DEPTH];
   logic [4:0]          ent_rd     [DEPTH];
   logic [31:0]         ent_value  [DEPTH];
   logic [31:0]         ent_alt_pc [DEPTH];
   logic [31:0]         ent_target [DEPTH];

   logic [IDX_BITS-1:0] head;
   logic [IDX_BITS-1:0] tail;
   logic [IDX_BITS:0]   cnt;
   logic [IDX_BITS:0]   n_commit;
   logic [IDX_BITS-1:0] slot_idx [COMMIT_WIDTH];
   logic                chain;
   logic                alloc_fire;
   logic                flush_now;

   assign count       = cnt;
   assign empty       = (cnt == '0);
   assign alloc_ready = (cnt < DEPTH_CNT) && rdy_in;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_id    = tail;

   assign q_ready_a = ent_valid[q_id_a] && ent_done[q_id_a];
   assign q_ready_b = ent_valid[q_id_b] && ent_done[q_id_b];
   assign q_value_a = ent_value[q_id_a];
   assign q_value_b = ent_value[q_id_b];

   // Retirement window: a contiguous run of done entries from head; only slot 0 may
   // retire a store, branch or jalr, and the first blocked slot ends the run.
   always_comb begin
      commit_valid = '0;
      commit_id    = '0;
      commit_rd    = '0;
      commit_value = '0;
      n_commit     = '0;
      chain        = rdy_in;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         slot_idx[k] = head + IDX_BITS'(k);
         chain = chain && (cnt > (IDX_BITS+1)'(k)) && ent_valid[slot_idx[k]]
                 && ent_done[slot_idx[k]] && ((k == 0) || (ent_kind[slot_idx[k]] == K_REG));
         if (chain) begin
            commit_valid[k]                     = 1'b1;
            commit_id[k*IDX_BITS +: IDX_BITS]   = slot_idx[k];
            commit_rd[k*5 +: 5]                 = (ent_kind[slot_idx[k]] == K_STORE ||
                                                   ent_kind[slot_idx[k]] == K_BRANCH) ? 5'd0
                                                  : ent_rd[slot_idx[k]];
            commit_value[k*32 +: 32]            = ent_value[slot_idx[k]];
            n_commit                            = n_commit + 1'b1;
         end
      end
   end

   assign store_commit = commit_valid[0] && (ent_kind[head] == K_STORE);
   assign flush_now    = commit_valid[0] &&
                         (((ent_kind[head] == K_BRANCH) && ent_value[head][0]) ||
                          (ent_kind[head] == K_JALR));

   // Control state: occupancy, pointers, completion flags and the flush pulse.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ent_valid    <= '0;
         ent_done     <= '0;
         head         <= '0;
         tail         <= '0;
         cnt          <= '0;
         jalr_pending <= 1'b0;
         flush_valid  <= 1'b0;
         flush_pc     <= '0;
      end else begin
         flush_valid <= 1'b0;
         if (rdy_in) begin
            if (flush_now) begin
               ent_valid    <= '0;
               ent_done     <= '0;
               head         <= '0;
               tail         <= '0;
               cnt          <= '0;
               jalr_pending <= 1'b0;
               flush_valid  <= 1'b1;
               flush_pc     <= (ent_kind[head] == K_BRANCH) ? ent_alt_pc[head] : ent_target[head];
            end else begin
               for (int k = 0; k < COMMIT_WIDTH; k++) begin
                  if (commit_valid[k]) begin
                     ent_valid[slot_idx[k]] <= 1'b0;
                     ent_done[slot_idx[k]]  <= 1'b0;
                  end
               end
               for (int p = 0; p < WB_PORTS; p++) begin
                  if (wb_valid[p] && ent_valid[wb_id[p*IDX_BITS +: IDX_BITS]]
                      && !ent_done[wb_id[p*IDX_BITS +: IDX_BITS]])
                     ent_done[wb_id[p*IDX_BITS +: IDX_BITS]] <= 1'b1;
               end
               if (alloc_fire) begin
                  ent_valid[tail] <= 1'b1;
                  ent_done[tail]  <= 1'b0;
                  tail            <= tail + 1'b1;
                  if (alloc_kind == K_JALR)
                     jalr_pending <= 1'b1;
               end
               head <= head + n_commit[IDX_BITS-1:0];
               cnt  <= cnt + {{IDX_BITS{1'b0}}, alloc_fire} - n_commit;
            end
         end
      end
   end

   // Entry payload; stale contents of invalid entries are never observed as valid.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && ent_valid[wb_id[p*IDX_BITS +: IDX_BITS]]
                && !ent_done[wb_id[p*IDX_BITS +: IDX_BITS]]) begin
               case (ent_kind[wb_id[p*IDX_BITS +: IDX_BITS]])
                  K_BRANCH: ent_value[wb_id[p*IDX_BITS +: IDX_BITS]][0] <=
                               wb_value[p*32] ^ ent_pred[wb_id[p*IDX_BITS +: IDX_BITS]];
                  K_JALR:   ent_target[wb_id[p*IDX_BITS +: IDX_BITS]] <= wb_value[p*32 +: 32];
                  default:  ent_value[wb_id[p*IDX_BITS +: IDX_BITS]]  <= wb_value[p*32 +: 32];
               endcase
            end
         end
         if (alloc_fire) begin
            ent_kind[tail]   <= alloc_kind;
            ent_rd[tail]     <= alloc_rd;
            ent_value[tail]  <= alloc_value;
            ent_alt_pc[tail] <= alloc_alt_pc;
            ent_pred[tail]   <= alloc_pred_taken;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc: directed scenarios plus randomized traffic checked
// each cycle against a program-order queue model of the buffer.
module tb_reorder_buffer_mc;
   localparam int IDX = 4, WBP = 2, CW = 2, DEPTH = 16;

   logic          clk_in = 1'b0;
   logic          rst_n_in, rdy_in;
   logic          alloc_valid, alloc_ready, alloc_pred_taken;
   logic [1:0]    alloc_kind;
   logic [4:0]    alloc_rd;
   logic [31:0]   alloc_value, alloc_alt_pc;
   logic [IDX-1:0] alloc_id, q_id_a, q_id_b;
   logic [WBP-1:0] wb_valid;
   logic [WBP*IDX-1:0] wb_id;
   logic [WBP*32-1:0]  wb_value;
   logic          q_ready_a, q_ready_b;
   logic [31:0]   q_value_a, q_value_b;
   logic [CW-1:0] commit_valid;
   logic [CW*IDX-1:0] commit_id;
   logic [CW*5-1:0]   commit_rd;
   logic [CW*32-1:0]  commit_value;
   logic          store_commit, flush_valid, jalr_pending, empty;
   logic [31:0]   flush_pc;
   logic [IDX:0]  count;

   always #5 clk_in = ~clk_in;

   reorder_buffer_mc #(.IDX_BITS(IDX), .WB_PORTS(WBP), .COMMIT_WIDTH(CW)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
      .alloc_rd(alloc_rd), .alloc_value(alloc_value), .alloc_alt_pc(alloc_alt_pc),
      .alloc_pred_taken(alloc_pred_taken), .alloc_id(alloc_id),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
      .q_id_a(q_id_a), .q_id_b(q_id_b), .q_ready_a(q_ready_a), .q_ready_b(q_ready_b),
      .q_value_a(q_value_a), .q_value_b(q_value_b),
      .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
      .commit_value(commit_value), .store_commit(store_commit),
      .flush_valid(flush_valid), .flush_pc(flush_pc), .jalr_pending(jalr_pending),
      .count(count), .empty(empty));

   typedef struct {
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] value;
      logic [31:0] alt_pc;
      logic [31:0] target;
      logic        pred;
      logic        done;
      logic [3:0]  id;
   } ent_t;

   ent_t        q[$];
   int          tail_id = 0;
   bit          exp_flush = 0;
   logic [31:0] exp_flush_pc = '0;
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find(input int id);
      for (int i = 0; i < q.size(); i++) if (q[i].id == 4'(id)) return i;
      return -1;
   endfunction

   function automatic bit has_jalr();
      for (int i = 0; i < q.size(); i++) if (q[i].kind == 2'd3) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_reset();
      q.delete();
      tail_id = 0;
      exp_flush = 0;
      exp_flush_pc = '0;
   endfunction

   // One clock: check outputs against the model at mid-low phase, then advance the model.
   task automatic tick();
      int nc, ia, ib;
      bit stop, fl, can_alloc;
      int hit[WBP];
      ent_t e;
      q_id_a = 4'($urandom_range(0, 15));
      q_id_b = 4'($urandom_range(0, 15));
      #1;
      nc = 0; stop = 0;
      if (rdy_in)
         for (int k = 0; k < CW; k++) begin
            if (!stop && k < q.size() && q[k].done && (k == 0 || q[k].kind == 2'd0)) nc++;
            else stop = 1;
         end
      can_alloc = rdy_in && (q.size() < DEPTH);
      chk("alloc_ready", alloc_ready, can_alloc);
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("alloc_id", alloc_id, tail_id);
      chk("jalr_pending", jalr_pending, has_jalr());
      chk("flush_valid", flush_valid, exp_flush);
      if (exp_flush) chk("flush_pc", flush_pc, exp_flush_pc);
      chk("commit_valid", commit_valid, (1 << nc) - 1);
      for (int k = 0; k < nc; k++) begin
         chk("commit_id", commit_id[k*IDX +: IDX], q[k].id);
         chk("commit_rd", commit_rd[k*5 +: 5],
             (q[k].kind == 2'd1 || q[k].kind == 2'd2) ? 5'd0 : q[k].rd);
         chk("commit_value", commit_value[k*32 +: 32], q[k].value);
      end
      chk("store_commit", store_commit, nc > 0 && q[0].kind == 2'd1);
      ia = find(q_id_a);
      ib = find(q_id_b);
      chk("q_ready_a", q_ready_a, (ia >= 0) ? q[ia].done : 1'b0);
      chk("q_ready_b", q_ready_b, (ib >= 0) ? q[ib].done : 1'b0);
      if (ia >= 0) chk("q_value_a", q_value_a, q[ia].value);
      if (ib >= 0) chk("q_value_b", q_value_b, q[ib].value);

      fl = nc > 0 && ((q[0].kind == 2'd2 && q[0].value[0]) || q[0].kind == 2'd3);
      if (!rdy_in) exp_flush = 0;
      else if (fl) begin
         exp_flush = 1;
         exp_flush_pc = (q[0].kind == 2'd2) ? q[0].alt_pc : q[0].target;
         q.delete();
         tail_id = 0;
      end else begin
         exp_flush = 0;
         for (int p = 0; p < WBP; p++) begin
            hit[p] = wb_valid[p] ? find(wb_id[p*IDX +: IDX]) : -1;
            if (hit[p] >= 0 && q[hit[p]].done) hit[p] = -1;
         end
         for (int p = 0; p < WBP; p++)
            if (hit[p] >= 0) begin
               e = q[hit[p]];
               e.done = 1;
               case (e.kind)
                  2'd2:    e.value[0] = wb_value[p*32] ^ e.pred;
                  2'd3:    e.target = wb_value[p*32 +: 32];
                  default: e.value = wb_value[p*32 +: 32];
               endcase
               q[hit[p]] = e;
            end
         for (int k = 0; k < nc; k++) void'(q.pop_front());
         if (alloc_valid && can_alloc) begin
            e.kind = alloc_kind; e.rd = alloc_rd; e.value = alloc_value;
            e.alt_pc = alloc_alt_pc; e.target = '0; e.pred = alloc_pred_taken;
            e.done = 0; e.id = 4'(tail_id);
            q.push_back(e);
            tail_id = (tail_id + 1) % DEPTH;
         end
      end
      @(negedge clk_in);
   endtask

   task automatic alloc1(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] v,
                         input logic [31:0] alt, input logic p);
      alloc_valid = 1; alloc_kind = k; alloc_rd = rd; alloc_value = v;
      alloc_alt_pc = alt; alloc_pred_taken = p;
      tick();
      alloc_valid = 0;
   endtask

   task automatic wb1(input int port, input logic [3:0] id, input logic [31:0] v);
      wb_valid = '0;
      wb_valid[port] = 1'b1;
      wb_id[port*IDX +: IDX] = id;
      wb_value[port*32 +: 32] = v;
      tick();
      wb_valid = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Random writeback strobes; with 'correct' set, branch outcomes match the prediction.
   task automatic pick_wb(input bit correct);
      int i;
      logic [3:0] id;
      logic [31:0] v;
      for (int p = 0; p < WBP; p++) begin
         wb_valid[p] = 1'($urandom_range(0, 1));
         if (q.size() > 0 && $urandom_range(0, 3) != 0) id = q[$urandom_range(0, q.size() - 1)].id;
         else id = 4'($urandom_range(0, 15));
         v = $urandom;
         i = find(id);
         if (correct && i >= 0 && q[i].kind == 2'd2) v[0] = q[i].pred;
         wb_id[p*IDX +: IDX] = id;
         wb_value[p*32 +: 32] = v;
      end
   endtask

   task automatic rand_alloc(input bit all_kinds);
      int r;
      r = $urandom_range(0, 9);
      alloc_kind = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9 || !all_kinds) ? 2'd2 : 2'd3;
      if (alloc_kind == 2'd3 && has_jalr()) alloc_kind = 2'd0;
      alloc_rd = 5'($urandom);
      alloc_value = (alloc_kind == 2'd2) ? 32'h0 : $urandom;
      alloc_alt_pc = $urandom;
      alloc_pred_taken = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int allocated, cyc;
      logic [3:0] id0;
      rst_n_in = 0; rdy_in = 1; alloc_valid = 0; alloc_kind = 0; alloc_rd = 0;
      alloc_value = 0; alloc_alt_pc = 0; alloc_pred_taken = 0;
      wb_valid = '0; wb_id = '0; wb_value = '0; q_id_a = 0; q_id_b = 0;
      model_reset();
      #2;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_flush_valid", flush_valid, 0);
      chk("rst_flush_pc", flush_pc, 0);
      chk("rst_jalr_pending", jalr_pending, 0);
      chk("rst_commit_valid", commit_valid, 0);
      repeat (3) @(negedge clk_in);
      rst_n_in = 1;

      // Fill to capacity, then an extra request must be refused.
      for (int i = 0; i < DEPTH; i++) alloc1(2'd0, 5'($urandom), $urandom, 0, 0);
      alloc_valid = 1; alloc_kind = 0;
      tick();
      alloc_valid = 0;
      chk("full_count", count, 16);
      chk("full_ready", alloc_ready, 0);
      chk("full_tail", alloc_id, 0);
      for (int i = 0; i < DEPTH; i++) wb1(i % 2, 4'(i), $urandom);
      idle(4);

      // Out-of-order writeback of ids 0..3.
      for (int i = 0; i < 4; i++) alloc1(2'd0, 5'(i + 1), 0, 0, 0);
      wb1(0, 4'd3, 32'h33); wb1(1, 4'd1, 32'h11); wb1(0, 4'd0, 32'h10); wb1(1, 4'd2, 32'h22);
      idle(3);

      // Mispredicted branch (predicted taken, actually not taken).
      id0 = 4'(tail_id);
      alloc1(2'd2, 5'd9, 0, 32'h100, 1);
      wb1(0, id0, 32'h0);
      idle(3);
      chk("after_flush_count", count, 0);

      // jalr: link value retires, then redirect to the target.
      id0 = 4'(tail_id);
      alloc1(2'd3, 5'd1, 32'h24, 0, 0);
      idle(2);
      wb1(1, id0, 32'h80);
      idle(3);

      // Store followed by reg-write, both done in one cycle.
      id0 = 4'(tail_id);
      alloc1(2'd1, 5'd4, 0, 0, 0);
      alloc1(2'd0, 5'd5, 0, 0, 0);
      wb_valid = 2'b11; wb_id = {id0 + 4'd1, id0}; wb_value = {32'hBEEF, 32'h5A5A};
      tick();
      wb_valid = '0;
      idle(3);

      // Correctly predicted branch, and two ports hitting the same id.
      id0 = 4'(tail_id);
      alloc1(2'd2, 5'd6, 0, 32'h200, 0);
      alloc1(2'd0, 5'd7, 0, 0, 0);
      wb_valid = 2'b11; wb_id = {id0 + 4'd1, id0 + 4'd1}; wb_value = {32'h2222, 32'h1111};
      tick();
      wb1(0, id0, 32'h0);
      idle(3);

      // 40 entries through the ring with a 3-cycle rdy_in drop.
      allocated = 0; cyc = 0;
      while ((allocated < 40 || q.size() != 0) && cyc < 400) begin
         bit acc;
         rdy_in = !(cyc >= 20 && cyc < 23);
         alloc_valid = (allocated < 40) && ($urandom_range(0, 3) != 0);
         rand_alloc(0);
         pick_wb(1);
         acc = alloc_valid && rdy_in && (q.size() < DEPTH);
         tick();
         if (acc) allocated++;
         cyc++;
      end
      alloc_valid = 0; wb_valid = '0; rdy_in = 1;
      chk("wrap_drained", count, 0);

      // Unconstrained random mix including mispredicts and jalr.
      for (int c = 0; c < 300; c++) begin
         rdy_in = ($urandom_range(0, 9) != 0);
         alloc_valid = !has_jalr() && ($urandom_range(0, 2) != 0);
         rand_alloc(1);
         pick_wb(0);
         tick();
      end
      alloc_valid = 0; wb_valid = '0; rdy_in = 1;

      // Asynchronous reset in the middle of the low phase.
      alloc1(2'd3, 5'd2, 32'h8, 0, 0);
      #2 rst_n_in = 0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_jalr", jalr_pending, 0);
      chk("async_rst_commit", commit_valid, 0);
      model_reset();
      @(negedge clk_in);
      rst_n_in = 1;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/reorder_buffer_mc.md
# reorder_buffer_mc

Parametrised reorder buffer for the out-of-order core. It allocates entries in program order from issue and accepts results from `WB_PORTS` independent writeback channels (RS ALU, LSB, extra units). It retires up to `COMMIT_WIDTH` completed entries per cycle to the register file and rename table. It signals a one-cycle registered flush with a redirect PC on branch mispredict or jalr.

## Interface
Parameters:
- `IDX_BITS`, 4, entry index width; depth `DEPTH = 2**IDX_BITS`.
- `WB_PORTS`, 2, number of writeback channels (1..4).
- `COMMIT_WIDTH`, 2, maximum retirements per cycle (1..4, ≤ DEPTH).

Ports. One clock; reset is asynchronous and active-low.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: asynchronous active-low reset.
- `rdy_in` in 1: global ready; low freezes all state.
- `alloc_valid` in 1: issue requests an entry.
- `alloc_ready` out 1: `count < DEPTH && rdy_in`.
- `alloc_kind` in 2: entry kind. 0 = reg-write, 1 = store, 2 = branch, 3 = jalr.
- `alloc_rd` in 5: destination register. Ignored for kinds 1 and 2.
- `alloc_value` in 32: initial value. For jalr this is the link value pc+4; for jal it is pc+4; otherwise 0.
- `alloc_alt_pc` in 32: branch non-predicted-path PC.
- `alloc_pred_taken` in 1: branch prediction.
- `alloc_id` out IDX_BITS: tail index; the id assigned to the current allocation.
- `wb_valid` in WB_PORTS: writeback strobes.
- `wb_id` in WB_PORTS*IDX_BITS: packed writeback entry ids, port p at `[p*IDX_BITS +: IDX_BITS]`.
- `wb_value` in WB_PORTS*32: packed writeback data.
  - Branch: bit 0 = actual taken.
  - jalr: target PC.
  - Other kinds: result.
- `q_id_a`, `q_id_b` in IDX_BITS: operand lookup ids.
- `q_ready_a`, `q_ready_b` out 1: entry valid and done.
- `q_value_a`, `q_value_b` out 32: entry value.
- `commit_valid` out COMMIT_WIDTH: slot k retires this cycle.
- `commit_id` out COMMIT_WIDTH*IDX_BITS: retiring entry ids.
- `commit_rd` out COMMIT_WIDTH*5: destination register; 0 for store and branch.
- `commit_value` out COMMIT_WIDTH*32: value to write.
- `store_commit` out 1: slot 0 retires a store this cycle.
- `flush_valid` out 1: registered one-cycle flush pulse.
- `flush_pc` out 32: redirect PC, valid with `flush_valid`.
- `jalr_pending` out 1: an unretired jalr is present; issue must stall.
- `count` out IDX_BITS+1: occupied entries.
- `empty` out 1: `count == 0`.

## Operation
- Per-entry state: `valid`, `done`, `kind`, `rd`, `value`, `alt_pc`, `pred`, `target`. Pointers `head` and `tail` wrap modulo DEPTH. `count` disambiguates full from empty.
- Allocation
  - `alloc_valid && alloc_ready` writes the entry at `tail` with `valid=1, done=0`.
  - `tail` then advances by 1 and `count` increments by 1.
  - Allocating a jalr sets `jalr_pending`.
- Writeback
  - For each port p with `wb_valid[p]`, when the entry is valid and not done: set `done`.
  - Kinds 0 and 1: `value <= wb_value`.
  - Branch: `value[0] <= wb_value[0] ^ pred`, so a set bit 0 means mispredict.
  - jalr: `target <= wb_value`; the link value is kept.
  - Writebacks to invalid or already-done entries are ignored.
  - When several ports hit the same id, the highest-index port wins.
- Commit (combinational from `head`)
  - Slot k is valid when `k < count` and entries `head..head+k` are all valid and done.
  - Slots k > 0 are additionally blocked if their entry is a store, branch or jalr, and every slot after a blocked slot is also invalid.
  - Kinds 1, 2 and 3 therefore retire only in slot 0.
  - `commit_rd` is forced to 0 for kinds 1 and 2.
  - At the edge, `head` and `count` advance by the number of valid slots, and those entries are cleared to `valid=0`.
- Flush
  - Triggered when slot 0 retires a mispredicted branch or any jalr.
  - All entries are invalidated, `head=tail=count=0`, and `jalr_pending=0`.
  - `flush_valid` is registered high for exactly the next cycle.
  - `flush_pc` is `alt_pc` for a branch and `target` for a jalr.
  - A same-cycle allocation or writeback is discarded.
- Retiring a correctly predicted branch or a reg-write produces no flush.
- `rdy_in` low: no allocation, commit or writeback takes effect; `commit_valid=0` and `store_commit=0`. `flush_valid` still deasserts after its one cycle.

## Timing
- Reset values: `head=tail=count=0`, all `valid=0`, `empty=1`, `alloc_ready=rdy_in`, `flush_valid=0`, `flush_pc=0`, `jalr_pending=0`, `commit_valid=0`.
- Reset mid-operation aborts immediately, asynchronously.
- Allocation at edge N makes the entry visible to queries in cycle N+1.
- Writeback at edge N makes the entry eligible to commit in cycle N+1 and retire at edge N+1.
- Queries do not bypass same-cycle writeback.
- `alloc_ready` depends only on the registered `count`. It does not reflect same-cycle commits: allocation is refused when full even if a commit occurs.
- Allocation and commit in the same cycle: `count` changes by `alloc - commits`.
- Pointers wrap from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset, then allocate 16 reg-writes (DEPTH=16). Expect `alloc_ready=0` and `count=16`; a 17th `alloc_valid` is ignored and `tail` stays 0.
- Allocate ids 0–3, write back 3,1,0,2 over separate cycles on ports 0/1. Expect commits of 0,1 together (COMMIT_WIDTH=2), then 2,3, with values matching.
- Allocate a branch with `pred_taken=1` and `alt_pc=0x100`, then write back 0. One cycle after its slot-0 commit, expect `flush_valid=1`, `flush_pc=0x100`, `count=0`, `empty=1`.
- Allocate a jalr with `alloc_value=0x24`, then write back target 0x80. Expect `jalr_pending=1` until retirement, then `commit_rd=rd` with value 0x24, then a flush to 0x80.
- Allocate store,reg-write both done. Expect cycle 1: slot 0 store with `store_commit=1` and slot 1 invalid; cycle 2: the reg-write commits.
- Run 40 entries through DEPTH=16 with the pointer wrapping. Toggle `rdy_in` low for 3 cycles mid-stream and expect no state change and `commit_valid=0`.
